// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word reads to a synchronous imem,
// and queues {pc, instr} pairs for decode over a valid/ready interface.
module fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_instr
);

    // Handshake: a transfer to decode happens on a rising edge where if_valid & if_ready;
    // if_pc/if_instr hold steady while if_valid & !if_ready.

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0] buf_pc    [BUF_DEPTH];
    logic [DATA_W-1:0] buf_instr [BUF_DEPTH];

    logic              pop;
    logic              push;
    logic              issue;
    logic [OCC_W-1:0]  occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign if_valid = (count != '0);
    assign if_pc    = if_valid ? buf_pc[rd_ptr]    : '0;
    assign if_instr = if_valid ? buf_instr[rd_ptr] : '0;

    assign pop  = if_valid & if_ready;
    assign push = inflight;

    // Credit counts the entry leaving this cycle so a stalled buffer refills without a bubble.
    assign occupancy = {1'b0, count} + OCC_W'(inflight) - OCC_W'(pop);
    assign issue     = !rst && !redirect_valid && (occupancy < DEPTH_C);
    assign imem_en   = issue;
    assign imem_addr = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            // Clearing inflight is what discards the response arriving next cycle.
            pc_q     <= redirect_pc;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) begin
                pc_q <= pc_q + ADDR_W'(1);
            end
            inflight <= issue;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= pc_q;
        end
        if (!rst && !redirect_valid && push) begin
            buf_pc[wr_ptr]    <= inflight_pc;
            buf_instr[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized phase,
// checked against a sequence-level model of the expected PC stream.
module tb_fetch_unit;

    localparam int               AW    = 32;
    localparam int               DW    = 32;
    localparam int               DEPTH = 2;
    localparam logic [AW-1:0]    RPC_A = 32'h0000_0000;
    localparam logic [AW-1:0]    RPC_B = 32'hFFFF_FFFE;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          if_ready;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [DW-1:0] if_instr;

    logic          imem_en_b;
    logic [AW-1:0] imem_addr_b;
    logic [DW-1:0] imem_rdata_b;
    logic          if_valid_b;
    logic [AW-1:0] if_pc_b;
    logic [DW-1:0] if_instr_b;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC_A), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC_B), .BUF_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst),
        .imem_en(imem_en_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
        .redirect_valid(1'b0), .redirect_pc('0),
        .if_valid(if_valid_b), .if_ready(1'b1), .if_pc(if_pc_b), .if_instr(if_instr_b)
    );

    function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Synchronous instruction memories: data one cycle after the strobe.
    always @(posedge clk) begin
        if (imem_en)   imem_rdata   <= instr_of(imem_addr);
        if (imem_en_b) imem_rdata_b <= instr_of(imem_addr_b);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_issue;
    logic [AW-1:0] exp_b;
    logic [AW-1:0] e_pc;
    int            outstanding;

    task automatic restart_stream(input logic [AW-1:0] start);
        exp_q.delete();
        exp_q.push_back(start);
        while (exp_q.size() < 4) exp_q.push_back(exp_q[exp_q.size()-1] + 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check_eq("rst_imem_en", imem_en, 1'b0);
            restart_stream(RPC_A);
            exp_issue   = RPC_A;
            outstanding = 0;
            exp_b       = RPC_B;
        end else begin
            if (if_valid && if_ready) begin
                e_pc = exp_q.pop_front();
                check_eq("pop_pc", if_pc, e_pc);
                check_eq("pop_instr", if_instr, instr_of(e_pc));
                while (exp_q.size() < 4) exp_q.push_back(exp_q[exp_q.size()-1] + 32'd1);
            end
            if (redirect_valid) begin
                check_eq("redir_imem_en", imem_en, 1'b0);
                restart_stream(redirect_pc);
                exp_issue   = redirect_pc;
                outstanding = 0;
            end else begin
                if (imem_en) begin
                    check_eq("issue_addr", imem_addr, exp_issue);
                    exp_issue = exp_issue + 32'd1;
                end
                outstanding = outstanding + int'(imem_en) - int'(if_valid && if_ready);
                check_eq("credit_bound", outstanding <= DEPTH, 1'b1);
            end
            if (if_valid_b) begin
                check_eq("b_pc", if_pc_b, exp_b);
                check_eq("b_instr", if_instr_b, instr_of(exp_b));
                exp_b = exp_b + 32'd1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_present(input logic [AW-1:0] target, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (if_valid && if_pc == target) found = 1'b1;
        end
        check_eq(tag, found, 1'b1);
    endtask

    task automatic wait_valid_check(input logic [AW-1:0] target, input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (if_valid) found = 1'b1;
        end
        check_eq({tag, "_seen"}, found, 1'b1);
        check_eq(tag, if_pc, target);
    endtask

    task automatic pulse_redirect(input logic [AW-1:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset, release, first fetches on both instances.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_if_valid", if_valid, 1'b0);
        check_eq("rst_if_pc", if_pc, '0);
        check_eq("rst_if_instr", if_instr, '0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t1_en_c1", imem_en, 1'b1);
        check_eq("t1_addr_c1", imem_addr, 32'd0);
        check_eq("t1_valid_c1", if_valid, 1'b0);
        @(negedge clk);
        check_eq("t1_valid_c2", if_valid, 1'b0);
        check_eq("t1_addr_c2", imem_addr, 32'd1);
        @(negedge clk);
        check_eq("t1_valid_c3", if_valid, 1'b1);
        check_eq("t1_pc0", if_pc, 32'd0);
        check_eq("t4_pc_fffffffe", if_pc_b, 32'hFFFF_FFFE);
        @(negedge clk);
        check_eq("t1_pc1", if_pc, 32'd1);
        check_eq("t4_pc_ffffffff", if_pc_b, 32'hFFFF_FFFF);
        @(negedge clk);
        check_eq("t1_pc2", if_pc, 32'd2);
        check_eq("t4_pc_wrap0", if_pc_b, 32'h0000_0000);
        @(negedge clk);
        check_eq("t1_pc3", if_pc, 32'd3);

        // Backpressure: pc 4 is presented and must freeze with fetch halted.
        step();
        if_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("t2_valid_held", if_valid, 1'b1);
            check_eq("t2_pc_frozen", if_pc, 32'd4);
            check_eq("t2_en_off", imem_en, 1'b0);
        end
        step();
        if_ready = 1'b1;
        @(negedge clk);
        check_eq("t2_resume_pc", if_pc, 32'd4);
        check_eq("t2_resume_en", imem_en, 1'b1);
        check_eq("t2_resume_addr", imem_addr, 32'd6);
        @(negedge clk);
        check_eq("t2_next5", if_pc, 32'd5);
        @(negedge clk);
        check_eq("t2_next6", if_pc, 32'd6);

        // Redirect while stalled with entries buffered and a fetch in flight.
        step();
        if_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        check_eq("t3_en_on_redirect", imem_en, 1'b0);
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        @(negedge clk);
        check_eq("t3_flushed", if_valid, 1'b0);
        check_eq("t3_addr_target", imem_addr, 32'h100);
        check_eq("t3_en_target", imem_en, 1'b1);
        @(negedge clk);
        check_eq("t3_no_stale", if_valid, 1'b0);
        @(negedge clk);
        check_eq("t3_pc100", if_pc, 32'h100);
        @(negedge clk);
        check_eq("t3_pc101", if_pc, 32'h101);
        @(negedge clk);
        check_eq("t3_pc102", if_pc, 32'h102);

        // Redirect in the same cycle as the pop of pc 5.
        step();
        pulse_redirect(32'h3);
        wait_present(32'h5, "t5_found_pc5");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        wait_valid_check(32'h40, "t5_target");

        // Reset pulse mid-stream at pc 0x20.
        pulse_redirect(32'h1E);
        wait_present(32'h20, "t6_found_pc20");
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_en_in_rst", imem_en, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_valid_after_rst", if_valid, 1'b0);
        wait_valid_check(RPC_A, "t6_refetch");

        // Randomized traffic: ready jitter, redirects (some near wrap), rare resets.
        for (int i = 0; i < 3000; i++) begin
            step();
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 1) == 0) ? AW'($urandom) : 32'hFFFF_FFFC;
            rst            = ($urandom_range(0, 199) == 0);
        end
        step();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
